// File: rtl/conf_regf_arbiter.sv
// rtl/conf_regf_arbiter.sv - round-robin sharing of the 16x8 config regfile between host single accesses and frame-engine bursts
module conf_regf_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic              a_wr,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_ack,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [LEN_W-1:0]  b_len,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_done,
    output logic              rf_wr_en,
    output logic              rf_rd_en,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [ADDR_W-1:0] rf_rd_addr,
    output logic [DATA_W-1:0] rf_data_in,
    input  logic [DATA_W-1:0] rf_data_out
);

    typedef enum logic [2:0] {
        IDLE, A_WR, A_RD, A_RWAIT, A_RDONE, B_RUN, B_TAIL
    } state_t;

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(16);

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;   // 1 = B was granted last
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic              b_rvalid_q, b_rvalid_d;
    logic [LEN_W-1:0]  len_clamp;
    logic              grant_a, grant_b;

    always_comb begin
        len_clamp    = (b_len > MAX_LEN) ? MAX_LEN : b_len;
        grant_a      = a_req && (!b_req || last_grant_q);
        grant_b      = b_req && !grant_a;
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wr_addr_d    = wr_addr_q;
        wdata_d      = wdata_q;
        rd_addr_d    = rd_addr_q;
        cnt_d        = cnt_q;
        a_rdata_d    = a_rdata_q;
        b_rvalid_d   = (state_q == B_RUN);

        case (state_q)
            IDLE: begin
                if (grant_a) begin
                    last_grant_d = 1'b0;
                    if (a_wr) begin
                        wr_addr_d = a_addr;
                        wdata_d   = a_wdata;
                        state_d   = A_WR;
                    end else begin
                        rd_addr_d = a_addr;
                        state_d   = A_RD;
                    end
                end else if (grant_b) begin
                    last_grant_d = 1'b1;
                    cnt_d        = len_clamp;
                    if (len_clamp == '0) begin
                        state_d = B_TAIL;
                    end else begin
                        rd_addr_d = b_addr;
                        state_d   = B_RUN;
                    end
                end
            end
            A_WR:    state_d = IDLE;
            A_RD:    state_d = A_RWAIT;
            A_RWAIT: begin
                a_rdata_d = rf_data_out;
                state_d   = A_RDONE;
            end
            A_RDONE: state_d = IDLE;
            B_RUN: begin
                cnt_d = cnt_q - LEN_W'(1);
                // Address stops on the last read so rf_rd_addr holds it afterwards
                if (cnt_q == LEN_W'(1)) begin
                    state_d = B_TAIL;
                end else begin
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                end
            end
            B_TAIL:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            wr_addr_q    <= '0;
            wdata_q      <= '0;
            rd_addr_q    <= '0;
            cnt_q        <= '0;
            a_rdata_q    <= '0;
            b_rvalid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wr_addr_q    <= wr_addr_d;
            wdata_q      <= wdata_d;
            rd_addr_q    <= rd_addr_d;
            cnt_q        <= cnt_d;
            a_rdata_q    <= a_rdata_d;
            b_rvalid_q   <= b_rvalid_d;
        end
    end

    assign rf_wr_en   = (state_q == A_WR);
    assign rf_rd_en   = (state_q == A_RD) || (state_q == B_RUN);
    assign rf_wr_addr = wr_addr_q;
    assign rf_rd_addr = rd_addr_q;
    assign rf_data_in = wdata_q;
    assign a_ack      = (state_q == A_WR) || (state_q == A_RDONE);
    assign a_rdata    = a_rdata_q;
    assign b_done     = (state_q == B_TAIL);
    assign b_rvalid   = b_rvalid_q;
    // Gated so the burst data port reads 0 outside a valid beat, including reset
    assign b_rdata    = b_rvalid_q ? rf_data_out : '0;

endmodule

// File: tb/tb_conf_regf_arbiter.sv
// tb/tb_conf_regf_arbiter.sv - directed self-checking bench for conf_regf_arbiter
module tb_conf_regf_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       a_req, a_wr;
    logic [3:0] a_addr;
    logic [7:0] a_wdata;
    logic       a_ack;
    logic [7:0] a_rdata;
    logic       b_req;
    logic [3:0] b_addr;
    logic [4:0] b_len;
    logic       b_rvalid;
    logic [7:0] b_rdata;
    logic       b_done;
    logic       rf_wr_en, rf_rd_en;
    logic [3:0] rf_wr_addr, rf_rd_addr;
    logic [7:0] rf_data_in;
    logic [7:0] rf_data_out = 8'h00;

    logic [7:0] mem [16];
    logic       preload_en = 1'b0;
    int         tests = 0;
    int         fails = 0;

    conf_regf_arbiter dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_addr(b_addr), .b_len(b_len),
        .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_done(b_done),
        .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en),
        .rf_wr_addr(rf_wr_addr), .rf_rd_addr(rf_rd_addr),
        .rf_data_in(rf_data_in), .rf_data_out(rf_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (preload_en) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'h10 + 8'(i);
        end else if (rf_wr_en) begin
            mem[rf_wr_addr] <= rf_data_in;
        end
        if (rf_rd_en) rf_data_out <= mem[rf_rd_addr];
    end

    task automatic preload();
        preload_en = 1'b1;
        @(negedge clk);
        preload_en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        a_req = 0; a_wr = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_addr = 0; b_len = 0;
        repeat (2) @(negedge clk);
        tests++;
        if ({a_ack, b_rvalid, b_done, rf_wr_en, rf_rd_en} !== 5'b0) begin
            fails++; $display("FAIL reset_strobes: got %b expected 00000", {a_ack, b_rvalid, b_done, rf_wr_en, rf_rd_en});
        end
        tests++;
        if ({a_rdata, b_rdata, rf_data_in} !== 24'h0) begin
            fails++; $display("FAIL reset_data: got %h expected 000000", {a_rdata, b_rdata, rf_data_in});
        end
        tests++;
        if ({rf_wr_addr, rf_rd_addr} !== 8'h0) begin
            fails++; $display("FAIL reset_addr: got %h expected 00", {rf_wr_addr, rf_rd_addr});
        end
        reset = 1'b1;
        @(negedge clk);
        tests++;
        if ({a_ack, b_done, rf_wr_en, rf_rd_en} !== 4'b0) begin
            fails++; $display("FAIL idle_quiet: got %b expected 0000", {a_ack, b_done, rf_wr_en, rf_rd_en});
        end
    endtask

    task automatic test_a_write();
        a_req = 1; a_wr = 1; a_addr = 4'd3; a_wdata = 8'h5A;
        tests++;
        if ({a_ack, rf_wr_en} !== 2'b00) begin
            fails++; $display("FAIL wr_grant_cycle: got %b expected 00", {a_ack, rf_wr_en});
        end
        @(negedge clk);
        a_addr = 4'd9; a_wdata = 8'h00;
        tests++;
        if ({a_ack, rf_wr_en, rf_rd_en} !== 3'b110) begin
            fails++; $display("FAIL wr_ack: got %b expected 110", {a_ack, rf_wr_en, rf_rd_en});
        end
        tests++;
        if ({rf_wr_addr, rf_data_in} !== 12'h35A) begin
            fails++; $display("FAIL wr_addr_data: got %h expected 35a", {rf_wr_addr, rf_data_in});
        end
        a_req = 0;
        @(negedge clk);
        tests++;
        if ({a_ack, rf_wr_en} !== 2'b00) begin
            fails++; $display("FAIL wr_single: got %b expected 00", {a_ack, rf_wr_en});
        end
        tests++;
        if ({rf_wr_addr, rf_data_in} !== 12'h35A) begin
            fails++; $display("FAIL wr_hold: got %h expected 35a", {rf_wr_addr, rf_data_in});
        end
    endtask

    task automatic test_a_read();
        a_req = 1; a_wr = 1; a_addr = 4'd7; a_wdata = 8'hC3;
        @(negedge clk);
        a_req = 0;
        @(negedge clk);
        a_req = 1; a_wr = 0; a_addr = 4'd7;
        @(negedge clk);
        a_addr = 4'd2;
        tests++;
        if ({rf_rd_en, rf_wr_en, a_ack, rf_rd_addr} !== 7'b100_0111) begin
            fails++; $display("FAIL rd_issue: got %b expected 1000111", {rf_rd_en, rf_wr_en, a_ack, rf_rd_addr});
        end
        @(negedge clk);
        tests++;
        if ({rf_rd_en, a_ack} !== 2'b00) begin
            fails++; $display("FAIL rd_wait: got %b expected 00", {rf_rd_en, a_ack});
        end
        @(negedge clk);
        tests++;
        if ({a_ack, a_rdata} !== 9'h1C3) begin
            fails++; $display("FAIL rd_ack_data: got %h expected 1c3", {a_ack, a_rdata});
        end
        a_req = 0;
        repeat (3) @(negedge clk);
        tests++;
        if ({a_ack, a_rdata} !== 9'h0C3) begin
            fails++; $display("FAIL rd_hold: got %h expected 0c3", {a_ack, a_rdata});
        end
    endtask

    task automatic run_burst(input logic [3:0] addr, input logic [4:0] len);
        int n, rd_cnt, rv_cnt, done_cyc;
        logic [3:0] ea;
        logic [7:0] ed;
        n = (len > 5'd16) ? 16 : int'(len);
        rd_cnt = 0; rv_cnt = 0; done_cyc = 0;
        b_req = 1; b_addr = addr; b_len = len;
        for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
            @(negedge clk);
            if (c == 1) begin b_addr = addr + 4'd7; b_len = 5'd2; end
            if (rf_rd_en) begin
                ea = addr + 4'(rd_cnt);
                tests++;
                if (rf_rd_addr !== ea) begin
                    fails++; $display("FAIL burst_rd_addr: got %h expected %h", rf_rd_addr, ea);
                end
                rd_cnt++;
            end
            if (b_rvalid) begin
                ea = addr + 4'(rv_cnt);
                ed = 8'h10 + {4'h0, ea};
                tests++;
                if (b_rdata !== ed) begin
                    fails++; $display("FAIL burst_data: got %h expected %h", b_rdata, ed);
                end
                tests++;
                if (c !== rv_cnt + 2) begin
                    fails++; $display("FAIL burst_rvalid_cycle: got %0d expected %0d", c, rv_cnt + 2);
                end
                rv_cnt++;
            end
            if (rf_wr_en) begin
                tests++; fails++; $display("FAIL burst_wr_en: got 1 expected 0");
            end
            if (b_done) begin
                done_cyc = c;
                b_req = 0;
                tests++;
                if (b_rvalid !== (n > 0)) begin
                    fails++; $display("FAIL burst_done_with_last: got %b expected %b", b_rvalid, n > 0);
                end
            end
        end
        tests++;
        if (done_cyc !== n + 1) begin
            fails++; $display("FAIL burst_done_cycle: got %0d expected %0d", done_cyc, n + 1);
        end
        tests++;
        if (rd_cnt !== n || rv_cnt !== n) begin
            fails++; $display("FAIL burst_count: got rd %0d rv %0d expected %0d", rd_cnt, rv_cnt, n);
        end
        b_req = 0;
        @(negedge clk);
        tests++;
        if ({b_done, b_rvalid, rf_rd_en} !== 3'b000) begin
            fails++; $display("FAIL burst_after: got %b expected 000", {b_done, b_rvalid, rf_rd_en});
        end
        if (n > 0) begin
            ea = addr + 4'(n - 1);
            tests++;
            if (rf_rd_addr !== ea) begin
                fails++; $display("FAIL burst_addr_hold: got %h expected %h", rf_rd_addr, ea);
            end
        end
    endtask

    task automatic test_arbitration();
        int rv, done_cyc;
        reset = 0;
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        a_req = 1; a_wr = 1; a_addr = 4'd5; a_wdata = 8'h15;
        b_req = 1; b_addr = 4'd0; b_len = 5'd16;
        @(negedge clk);
        tests++;
        if ({a_ack, rf_wr_en, rf_rd_en, rf_wr_addr} !== 7'b110_0101) begin
            fails++; $display("FAIL arb_first_a: got %b expected 1100101", {a_ack, rf_wr_en, rf_rd_en, rf_wr_addr});
        end
        a_addr = 4'd6; a_wdata = 8'h66;
        @(negedge clk);
        tests++;
        if ({a_ack, rf_rd_en} !== 2'b00) begin
            fails++; $display("FAIL arb_tie_b_grant: got %b expected 00", {a_ack, rf_rd_en});
        end
        rv = 0; done_cyc = 0;
        for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
            @(negedge clk);
            if (b_rvalid) rv++;
            if (a_ack) begin
                tests++; fails++; $display("FAIL arb_preempt: got a_ack at cycle %0d expected none", c);
            end
            if (b_done) begin
                done_cyc = c;
                b_addr = 4'd2; b_len = 5'd1;
            end
        end
        tests++;
        if (done_cyc !== 17 || rv !== 16) begin
            fails++; $display("FAIL arb_full_burst: got done %0d rv %0d expected 17 16", done_cyc, rv);
        end
        @(negedge clk);
        tests++;
        if ({a_ack, rf_rd_en, b_done} !== 3'b000) begin
            fails++; $display("FAIL arb_tie_a_grant: got %b expected 000", {a_ack, rf_rd_en, b_done});
        end
        @(negedge clk);
        tests++;
        if ({a_ack, rf_wr_en, rf_wr_addr, rf_data_in} !== 14'b1_1_0110_01100110) begin
            fails++; $display("FAIL arb_a_after_done: got %b expected 11011001100110", {a_ack, rf_wr_en, rf_wr_addr, rf_data_in});
        end
        a_req = 0;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if ({rf_rd_en, rf_rd_addr} !== 5'b1_0010) begin
            fails++; $display("FAIL arb_b_again: got %b expected 10010", {rf_rd_en, rf_rd_addr});
        end
        @(negedge clk);
        tests++;
        if ({b_done, b_rvalid, b_rdata} !== 10'b11_00010010) begin
            fails++; $display("FAIL arb_b_again_data: got %b expected 1100010010", {b_done, b_rvalid, b_rdata});
        end
        b_req = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        int rv;
        preload();
        a_req = 1; a_wr = 0; a_addr = 4'd7;
        repeat (3) @(negedge clk);
        tests++;
        if ({a_ack, a_rdata} !== 9'h117) begin
            fails++; $display("FAIL mid_pre_read: got %h expected 117", {a_ack, a_rdata});
        end
        a_req = 0;
        @(negedge clk);
        b_req = 1; b_addr = 4'd3; b_len = 5'd10;
        rv = 0;
        for (int c = 1; c <= 40 && rv < 5; c++) begin
            @(negedge clk);
            if (b_rvalid) rv++;
        end
        tests++;
        if (rv !== 5) begin
            fails++; $display("FAIL mid_rvalid_timeout: got %0d expected 5", rv);
        end
        reset = 0;
        b_req = 0;
        #1;
        tests++;
        if ({a_ack, b_rvalid, b_done, rf_wr_en, rf_rd_en} !== 5'b0) begin
            fails++; $display("FAIL mid_reset_strobes: got %b expected 00000", {a_ack, b_rvalid, b_done, rf_wr_en, rf_rd_en});
        end
        tests++;
        if ({a_rdata, b_rdata, rf_data_in, rf_wr_addr, rf_rd_addr} !== 32'h0) begin
            fails++; $display("FAIL mid_reset_data: got %h expected 00000000", {a_rdata, b_rdata, rf_data_in, rf_wr_addr, rf_rd_addr});
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests++;
            if ({b_done, b_rvalid} !== 2'b00) begin
                fails++; $display("FAIL mid_no_done: got %b expected 00", {b_done, b_rvalid});
            end
        end
        reset = 1;
        @(negedge clk);
        run_burst(4'd9, 5'd3);
    endtask

    initial begin
        test_reset();
        test_a_write();
        test_a_read();
        preload();
        run_burst(4'd14, 5'd4);
        run_burst(4'd9, 5'd0);
        run_burst(4'd5, 5'd20);
        test_arbitration();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
